// File: rtl/gif_capture_ctrl.sv
// gif_capture_ctrl: sequences a 1-bit frame buffer for multi-frame GIF capture.
// Writes NUM_FRAMES camera frames (one in every FRAME_SKIP) into consecutive
// buffer slots, then streams every buffer address to the encoder over a
// valid/ready handshake.
module gif_capture_ctrl #(
    parameter int H          = 320,
    parameter int V          = 240,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_SKIP = 2,
    parameter int ADDR_W     = 19,
    localparam int SLOT_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic              pix_valid_in,
    input  logic              pix_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic              wr_data_out,
    output logic              rd_valid_out,
    input  logic              rd_ready_in,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic              rd_last_out,
    output logic [SLOT_W-1:0] slot_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam int SKIP_W = (FRAME_SKIP > 1) ? $clog2(FRAME_SKIP) : 1;

    localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(H * V);
    localparam logic [ADDR_W-1:0] LINE_PIX  = ADDR_W'(H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_FRAMES * H * V - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_FRAMES - 1);
    localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(FRAME_SKIP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_SKIP,
        S_READOUT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] slot_nxt;
    logic [SKIP_W-1:0] skip_cnt;
    logic [SKIP_W-1:0] skip_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_addr_nxt;

    logic              in_range;
    logic              frame_start;
    logic              frame_end;
    logic              wr_qual;
    logic [ADDR_W-1:0] wr_addr_nxt;

    // Pixel classification: only in-range pixels can start, end or fill a frame.
    assign in_range    = pix_valid_in && (int'(hcount_in) < H) && (int'(vcount_in) < V);
    assign frame_start = in_range && (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign frame_end   = in_range && (int'(hcount_in) == H - 1) && (int'(vcount_in) == V - 1);

    // The fs pixel is written from ARM; abort suppresses the write of its own cycle.
    assign wr_qual = !abort_in &&
                     (((state == S_ARM) && frame_start) ||
                      ((state == S_CAPTURE) && in_range));

    assign wr_addr_nxt = ADDR_W'(slot) * FRAME_PIX
                       + ADDR_W'(vcount_in) * LINE_PIX
                       + ADDR_W'(hcount_in);

    // Control state register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state    <= S_IDLE;
            slot     <= '0;
            skip_cnt <= '0;
            rd_addr  <= '0;
        end else begin
            state    <= state_nxt;
            slot     <= slot_nxt;
            skip_cnt <= skip_nxt;
            rd_addr  <= rd_addr_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt    = state;
        slot_nxt     = slot;
        skip_nxt     = skip_cnt;
        rd_addr_nxt  = rd_addr;
        rd_valid_out = 1'b0;
        rd_last_out  = 1'b0;
        busy_out     = 1'b0;
        done_out     = 1'b0;

        case (state)
            S_ARM, S_CAPTURE, S_SKIP: busy_out = 1'b1;
            S_READOUT: begin
                busy_out     = 1'b1;
                rd_valid_out = 1'b1;
                rd_last_out  = (rd_addr == LAST_ADDR);
            end
            S_DONE:  done_out = 1'b1;
            default: ;
        endcase

        if (abort_in) begin
            state_nxt   = S_IDLE;
            slot_nxt    = '0;
            skip_nxt    = '0;
            rd_addr_nxt = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_in) begin
                        state_nxt = S_ARM;
                        slot_nxt  = '0;
                    end
                end
                S_ARM: begin
                    if (frame_start) begin
                        state_nxt = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (frame_end) begin
                        if (slot == LAST_SLOT) begin
                            state_nxt   = S_READOUT;
                            rd_addr_nxt = '0;
                        end else begin
                            slot_nxt = slot + SLOT_W'(1);
                            if (FRAME_SKIP == 1) begin
                                state_nxt = S_ARM;
                            end else begin
                                state_nxt = S_SKIP;
                                skip_nxt  = SKIP_LOAD;
                            end
                        end
                    end
                end
                S_SKIP: begin
                    if (frame_end) begin
                        if (skip_cnt <= SKIP_W'(1)) begin
                            state_nxt = S_ARM;
                            skip_nxt  = '0;
                        end else begin
                            skip_nxt = skip_cnt - SKIP_W'(1);
                        end
                    end
                end
                S_READOUT: begin
                    // Hold the final address on its acceptance so it never wraps.
                    if (rd_ready_in) begin
                        if (rd_addr == LAST_ADDR) begin
                            state_nxt = S_DONE;
                        end else begin
                            rd_addr_nxt = rd_addr + ADDR_W'(1);
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Write port: one-cycle registered copy of each qualified pixel.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wr_en_out   <= 1'b0;
            wr_addr_out <= '0;
            wr_data_out <= 1'b0;
        end else begin
            wr_en_out <= wr_qual;
            if (wr_qual) begin
                wr_addr_out <= wr_addr_nxt;
                wr_data_out <= pix_in;
            end
        end
    end

    assign rd_addr_out = rd_addr;
    assign slot_out    = slot;

endmodule

// File: tb/tb_gif_capture_ctrl.sv
// tb_gif_capture_ctrl: two controllers (FRAME_SKIP 1 and 3) share one pixel
// stream; a frame-index model predicts every write, slot and readout address.
module tb_gif_capture_ctrl;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int NF    = 2;
    localparam int AW    = 4;
    localparam int TOTAL = NF * H * V;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort, pv, pix, rdy_a, rdy_b;
    logic [10:0] hc;
    logic [9:0]  vc;

    logic          wr_en    [2];
    logic [AW-1:0] wr_addr  [2];
    logic          wr_data  [2];
    logic          rd_valid [2];
    logic [AW-1:0] rd_addr  [2];
    logic          rd_last  [2];
    logic          slot     [2];
    logic          busy     [2];
    logic          done     [2];

    gif_capture_ctrl #(.H(H), .V(V), .NUM_FRAMES(NF), .FRAME_SKIP(1), .ADDR_W(AW)) dut_a (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .abort_in(abort),
        .pix_valid_in(pv), .pix_in(pix), .hcount_in(hc), .vcount_in(vc),
        .wr_en_out(wr_en[0]), .wr_addr_out(wr_addr[0]), .wr_data_out(wr_data[0]),
        .rd_valid_out(rd_valid[0]), .rd_ready_in(rdy_a), .rd_addr_out(rd_addr[0]),
        .rd_last_out(rd_last[0]), .slot_out(slot[0]), .busy_out(busy[0]), .done_out(done[0])
    );

    gif_capture_ctrl #(.H(H), .V(V), .NUM_FRAMES(NF), .FRAME_SKIP(3), .ADDR_W(AW)) dut_b (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .abort_in(abort),
        .pix_valid_in(pv), .pix_in(pix), .hcount_in(hc), .vcount_in(vc),
        .wr_en_out(wr_en[1]), .wr_addr_out(wr_addr[1]), .wr_data_out(wr_data[1]),
        .rd_valid_out(rd_valid[1]), .rd_ready_in(rdy_b), .rd_addr_out(rd_addr[1]),
        .rd_last_out(rd_last[1]), .slot_out(slot[1]), .busy_out(busy[1]), .done_out(done[1])
    );

    int tests = 0;
    int fails = 0;

    // Model: frame index counted from the first fs after start; frame f is
    // captured into slot f/skip when f is a multiple of skip and f/skip < NF.
    int         fsk      [2] = '{1, 3};
    bit         m_started[2];
    int         m_fidx   [2];
    int         m_cap    [2];
    int         m_phase  [2];   // 0 capturing, 1 readout, 2 done
    int         m_raddr  [2];
    logic [TOTAL-1:0] acc_map [2];

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic model_clear(input int i);
        m_started[i] = 1'b0;
        m_fidx[i]    = -1;
        m_cap[i]     = 0;
        m_phase[i]   = 0;
        m_raddr[i]   = 0;
    endtask

    // One clock: drive inputs at the falling edge, update the model, check after the rising edge.
    task automatic step(input bit r_n, input bit st, input bit ab, input bit v, input int h,
                        input int vv, input bit p, input bit ra, input bit rb);
        bit            we [2];
        logic [AW-1:0] wa [2];
        bit            inr, is_fs, is_fe, rdy_i, can_start;
        int            slot_exp;
        rst_n = r_n; start = st; abort = ab; pv = v;
        hc = 11'(h); vc = 10'(vv); pix = p; rdy_a = ra; rdy_b = rb;
        #1;
        inr   = v && (h >= 0) && (h < H) && (vv >= 0) && (vv < V);
        is_fs = inr && (h == 0) && (vv == 0);
        is_fe = inr && (h == H - 1) && (vv == V - 1);
        for (int i = 0; i < 2; i++) begin
            rdy_i = (i == 0) ? ra : rb;
            if (r_n && rd_valid[i] && rdy_i) acc_map[i][rd_addr[i]] = 1'b1;
            we[i] = 1'b0;
            wa[i] = '0;
            can_start = !m_started[i] || (m_phase[i] == 2);
            if (!r_n || ab) begin
                model_clear(i);
            end else begin
                if (m_started[i] && m_phase[i] == 0 && inr) begin
                    if (is_fs) m_fidx[i]++;
                    if (m_fidx[i] >= 0 && (m_fidx[i] % fsk[i]) == 0 && (m_fidx[i] / fsk[i]) < NF) begin
                        we[i] = 1'b1;
                        wa[i] = AW'((m_fidx[i] / fsk[i]) * H * V + vv * H + h);
                        if (is_fe) begin
                            m_cap[i]++;
                            if (m_fidx[i] / fsk[i] == NF - 1) begin
                                m_phase[i] = 1;
                                m_raddr[i] = 0;
                            end
                        end
                    end
                end else if (m_phase[i] == 1 && rdy_i) begin
                    if (m_raddr[i] == TOTAL - 1) m_phase[i] = 2;
                    else m_raddr[i]++;
                end
                if (st && can_start) begin
                    m_started[i] = 1'b1;
                    m_fidx[i]    = -1;
                    m_cap[i]     = 0;
                    m_phase[i]   = 0;
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("wr_en", i, 32'(wr_en[i]), 32'(we[i]));
            if (we[i]) begin
                chk("wr_addr", i, 32'(wr_addr[i]), 32'(wa[i]));
                chk("wr_data", i, 32'(wr_data[i]), 32'(p));
            end
            chk("rd_valid", i, 32'(rd_valid[i]), 32'(m_phase[i] == 1));
            if (m_phase[i] == 1) begin
                chk("rd_addr", i, 32'(rd_addr[i]), 32'(m_raddr[i]));
                chk("rd_last", i, 32'(rd_last[i]), 32'(m_raddr[i] == TOTAL - 1));
            end else begin
                chk("rd_last", i, 32'(rd_last[i]), 32'd0);
            end
            chk("busy", i, 32'(busy[i]), 32'(m_started[i] && m_phase[i] != 2));
            chk("done", i, 32'(done[i]), 32'(m_started[i] && m_phase[i] == 2));
            slot_exp = m_started[i] ? ((m_cap[i] < NF - 1) ? m_cap[i] : NF - 1) : 0;
            chk("slot", i, 32'(slot[i]), 32'(slot_exp));
            if (!r_n) begin
                chk("rst_wr_addr", i, 32'(wr_addr[i]), 32'd0);
                chk("rst_wr_data", i, 32'(wr_data[i]), 32'd0);
                chk("rst_rd_addr", i, 32'(rd_addr[i]), 32'd0);
            end
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    // 0..2 cycles of non-qualifying pixels: invalid, h out of range, or v out of range.
    task automatic junk(input bit noise);
        int n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
            bit st = noise && ($urandom_range(0, 7) == 0);
            bit p  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       step(1'b1, st, 1'b0, 1'b0, $urandom_range(0, H - 1), $urandom_range(0, V - 1), p, 1'b0, 1'b0);
                1:       step(1'b1, st, 1'b0, 1'b1, 9, $urandom_range(0, V - 1), p, 1'b0, 1'b0);
                default: step(1'b1, st, 1'b0, 1'b1, $urandom_range(0, H - 1), 3, p, 1'b0, 1'b0);
            endcase
        end
    endtask

    task automatic frame(input bit noise, input int abort_at);
        int k = 0;
        for (int vv = 0; vv < V; vv++) begin
            for (int h = 0; h < H; h++) begin
                junk(noise);
                step(1'b1, 1'b0, (k == abort_at), 1'b1, h, vv, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                k++;
            end
        end
    endtask

    // Drain instance i; optional 1,0,0,1 ready prefix; optional reset when address rst_at is presented.
    task automatic readout(input int i, input bit toggle, input int rst_at);
        int n = 0;
        bit r;
        while (m_phase[i] == 1 && n < 200) begin
            if (rst_at >= 0 && m_raddr[i] == rst_at) begin
                step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
                idle();
                break;
            end
            if (toggle && n < 4) r = (n == 0) || (n == 3);
            else                 r = ($urandom_range(0, 3) != 0);
            step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, (i == 0) ? r : 1'b0, (i == 1) ? r : 1'b0);
            n++;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            model_clear(i);
            acc_map[i] = '0;
        end
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pv = 1'b0; pix = 1'b0;
        hc = '0; vc = '0; rdy_a = 1'b0; rdy_b = 1'b0;

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle();

        // Start mid-frame: the tail of this frame must not be written.
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        junk(1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 2, 1, 1'b1, 1'b0, 1'b0);
        junk(1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3, 1, 1'b1, 1'b0, 1'b0);

        // Five frames: skip-1 captures frames 1-2, skip-3 captures frames 1 and 4.
        repeat (5) frame(1'b1, -1);

        readout(0, 1'b1, -1);
        chk("accepted_unique", 0, 32'($countones(acc_map[0])), 32'(TOTAL));

        // Restart from DONE, then reset the other instance mid-readout at address 5.
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        readout(1, 1'b0, 5);

        // Abort during slot-1 capture, then restart at slot 0.
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, -1);
        frame(1'b0, 3);
        idle();
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, -1);
        repeat (2) idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
